// File: rtl/cmac_block_sequencer_if.sv
// Block-fetch bus: BRAM read port plus the valid/ready block channel to the AES-CMAC core.
// master = sequencer side, slave = BRAM/core side.
interface cmac_block_sequencer_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 128
);
    logic              bram_en;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_dout;
    logic [DATA_W-1:0] blk_data;
    logic              blk_valid;
    logic              blk_ready;
    logic              blk_last;
    logic              blk_complete;

    modport master (
        output bram_en, bram_addr, blk_data, blk_valid, blk_last, blk_complete,
        input  bram_dout, blk_ready
    );
    modport slave (
        input  bram_en, bram_addr, blk_data, blk_valid, blk_last, blk_complete,
        output bram_dout, blk_ready
    );
endinterface

// File: rtl/cmac_block_sequencer.sv
// Fetch sequencer: turns a bit length into BRAM block reads and hands masked blocks to the CMAC core.
// Optional build macro CMAC_PAD_EN: apply 10* padding to the final incomplete block.
module cmac_block_sequencer #(
    parameter int ADDR_W    = 9,
    parameter int DATA_W    = 128,
    parameter int LEN_W     = 16,
    parameter int BASE_ADDR = 0,
    parameter int RD_LAT    = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic             err,
    cmac_block_sequencer_if.master bus
);
    localparam int CNT_W = LEN_W - 6;
    localparam logic [2:0] LAT_M1 = 3'(RD_LAT - 1);
`ifdef CMAC_PAD_EN
    localparam logic [DATA_W-1:0] EMPTY_BLK = {1'b1, {(DATA_W-1){1'b0}}};
`else
    localparam logic [DATA_W-1:0] EMPTY_BLK = '0;
`endif

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, PRESENT, DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  idx_q, idx_d, last_idx_q, last_idx_d;
    logic [6:0]        rem_q, rem_d;
    logic              cmpl_q, cmpl_d;
    logic [2:0]        lat_q, lat_d;
    logic              armed_q;
    logic              bram_en_q, bram_en_d;
    logic [ADDR_W-1:0] bram_addr_q, bram_addr_d;
    logic [DATA_W-1:0] blk_data_q, blk_data_d;
    logic              blk_valid_q, blk_valid_d;
    logic              blk_last_q, blk_last_d;
    logic              blk_complete_q, blk_complete_d;
    logic              busy_q, busy_d, done_q, done_d, err_q, err_d;

    logic [LEN_W:0]    len_rnd;
    logic [CNT_W-1:0]  nblk;
    logic              ovf, fin;
    logic [DATA_W-1:0] shaped;

    function automatic logic [ADDR_W-1:0] addr_of(input logic [CNT_W-1:0] i);
        return ADDR_W'(BASE_ADDR) + ADDR_W'(i);
    endfunction

    assign len_rnd = {1'b0, len} + (LEN_W+1)'(127);
    assign nblk    = (len == '0) ? CNT_W'(1) : len_rnd[LEN_W:7];
    assign ovf     = (32'(BASE_ADDR) + 32'(nblk)) > (32'd1 << ADDR_W);
    assign fin     = (idx_q == last_idx_q);

    // Final block keeps only its rem leading message bits.
    always_comb begin
        shaped = bus.bram_dout;
        if (fin && rem_q != 7'd0) shaped = shaped & ~({DATA_W{1'b1}} >> rem_q);
`ifdef CMAC_PAD_EN
        if (fin && !cmpl_q) shaped = shaped | (EMPTY_BLK >> rem_q);
`endif
    end

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        last_idx_d     = last_idx_q;
        rem_d          = rem_q;
        cmpl_d         = cmpl_q;
        lat_d          = lat_q;
        bram_en_d      = 1'b0;
        bram_addr_d    = bram_addr_q;
        blk_data_d     = blk_data_q;
        blk_valid_d    = blk_valid_q;
        blk_last_d     = blk_last_q;
        blk_complete_d = blk_complete_q;
        busy_d         = busy_q;
        done_d         = 1'b0;
        err_d          = 1'b0;
        case (state_q)
            IDLE: if (start && armed_q) begin
                if (ovf) begin
                    err_d = 1'b1;
                end else begin
                    busy_d     = 1'b1;
                    idx_d      = '0;
                    last_idx_d = nblk - CNT_W'(1);
                    rem_d      = len[6:0];
                    cmpl_d     = (len != '0) && (len[6:0] == 7'd0);
                    if (len == '0) begin
                        state_d        = PRESENT;
                        blk_data_d     = EMPTY_BLK;
                        blk_valid_d    = 1'b1;
                        blk_last_d     = 1'b1;
                        blk_complete_d = 1'b0;
                    end else begin
                        state_d     = ISSUE;
                        bram_en_d   = 1'b1;
                        bram_addr_d = addr_of('0);
                    end
                end
            end
            ISSUE: begin
                state_d = WAIT;
                lat_d   = LAT_M1;
            end
            WAIT: begin
                if (lat_q == 3'd0) begin
                    state_d        = PRESENT;
                    blk_data_d     = shaped;
                    blk_valid_d    = 1'b1;
                    blk_last_d     = fin;
                    blk_complete_d = fin && cmpl_q;
                end else begin
                    lat_d = lat_q - 3'd1;
                end
            end
            PRESENT: if (bus.blk_ready) begin
                blk_valid_d    = 1'b0;
                blk_last_d     = 1'b0;
                blk_complete_d = 1'b0;
                if (fin) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    state_d     = ISSUE;
                    idx_d       = idx_q + CNT_W'(1);
                    bram_en_d   = 1'b1;
                    bram_addr_d = addr_of(idx_q + CNT_W'(1));
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // armed_q blocks a start that coincides with reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            last_idx_q     <= '0;
            rem_q          <= '0;
            cmpl_q         <= 1'b0;
            lat_q          <= '0;
            armed_q        <= 1'b0;
            bram_en_q      <= 1'b0;
            bram_addr_q    <= '0;
            blk_data_q     <= '0;
            blk_valid_q    <= 1'b0;
            blk_last_q     <= 1'b0;
            blk_complete_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            last_idx_q     <= last_idx_d;
            rem_q          <= rem_d;
            cmpl_q         <= cmpl_d;
            lat_q          <= lat_d;
            armed_q        <= 1'b1;
            bram_en_q      <= bram_en_d;
            bram_addr_q    <= bram_addr_d;
            blk_data_q     <= blk_data_d;
            blk_valid_q    <= blk_valid_d;
            blk_last_q     <= blk_last_d;
            blk_complete_q <= blk_complete_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            err_q          <= err_d;
        end
    end

    assign bus.bram_en      = bram_en_q;
    assign bus.bram_addr    = bram_addr_q;
    assign bus.blk_data     = blk_data_q;
    assign bus.blk_valid    = blk_valid_q;
    assign bus.blk_last     = blk_last_q;
    assign bus.blk_complete = blk_complete_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign err              = err_q;
endmodule

// File: tb/tb_cmac_block_sequencer.sv
// Bench for cmac_block_sequencer: vector table, randomized messages against a bit-level
// message model, plus hand sequences for stall, mid-message reset and BRAM overflow.
module tb_cmac_block_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [15:0] len_in = '0;
    logic        busy, done, err;
    logic        start_o = 1'b0;
    logic [15:0] len_o = '0;
    logic        busy_o, done_o, err_o;

    always #5 clk = ~clk;

    cmac_block_sequencer_if #(.ADDR_W(9), .DATA_W(128)) bi();
    cmac_block_sequencer_if #(.ADDR_W(9), .DATA_W(128)) bo();

    cmac_block_sequencer #(.ADDR_W(9), .DATA_W(128), .LEN_W(16), .BASE_ADDR(0), .RD_LAT(1)) u_dut (
        .clk(clk), .reset(reset), .start(start), .len(len_in),
        .busy(busy), .done(done), .err(err), .bus(bi));

    cmac_block_sequencer #(.ADDR_W(9), .DATA_W(128), .LEN_W(16), .BASE_ADDR(500), .RD_LAT(1)) u_ovf (
        .clk(clk), .reset(reset), .start(start_o), .len(len_o),
        .busy(busy_o), .done(done_o), .err(err_o), .bus(bo));

    logic [127:0] mem [0:511];
    always @(posedge clk) if (bi.bram_en) bi.bram_dout <= mem[bi.bram_addr];
    assign bo.bram_dout = '0;
    assign bo.blk_ready = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic int model_nblk(input int l);
        return (l == 0) ? 1 : (l + 127) / 128;
    endfunction

    // Block k carries message bits k*128 .. k*128+127, MSB first; bits past len are dropped.
    function automatic logic [127:0] model_blk(input int l, input int k);
        logic [127:0] r;
        r = (l == 0) ? 128'd0 : mem[k];
        for (int i = 0; i < 128; i++) begin
            int p;
            p = k * 128 + 127 - i;
            if (p >= l) r[i] = 1'b0;
`ifdef CMAC_PAD_EN
            if (p == l) r[i] = 1'b1;
`endif
        end
        return r;
    endfunction

    task automatic run_msg(input int l, input int pct, input int stall,
                           output int nblk_got, output int first_cyc, output int done_cyc,
                           output logic cmpl_got, output logic [127:0] last_data);
        int nb, rd_i, blk_i, cyc, stall_n;
        bit fin, r;
        nb = model_nblk(l);
        rd_i = 0; blk_i = 0; cyc = 0; stall_n = 0; fin = 0;
        first_cyc = -1; done_cyc = -1; cmpl_got = 1'bx; last_data = 'x;
        @(negedge clk);
        start = 1'b1; len_in = 16'(l);
        while (!fin && cyc < 4000) begin
            @(negedge clk);
            start = 1'b0;
            len_in = 16'($urandom);
            cyc++;
            chk("err_idle", {127'd0, err}, 128'd0);
            if (bi.bram_en) begin
                chk("rd_addr", {119'd0, bi.bram_addr}, 128'(rd_i));
                chk("rd_while_valid", {127'd0, bi.blk_valid}, 128'd0);
                rd_i++;
            end
            if (bi.blk_valid) begin
                if (first_cyc < 0) first_cyc = cyc;
                chk("blk_data", bi.blk_data, model_blk(l, blk_i));
                chk("blk_last", {127'd0, bi.blk_last}, {127'd0, blk_i == nb - 1});
                chk("blk_complete", {127'd0, bi.blk_complete},
                    {127'd0, (blk_i == nb - 1) && l != 0 && (l % 128) == 0});
                if (blk_i == nb - 1) begin
                    cmpl_got = bi.blk_complete;
                    last_data = bi.blk_data;
                end
            end
            if (done) begin
                fin = 1;
                done_cyc = cyc;
            end else begin
                chk("busy", {127'd0, busy}, 128'd1);
            end
            if (bi.blk_valid && blk_i == 0 && stall_n < stall) begin
                r = 0;
                stall_n++;
                if (stall_n == 5) begin
                    start = 1'b1;
                    len_in = 16'd128;
                end
            end else begin
                r = ($urandom_range(0, 99) < pct);
            end
            bi.blk_ready = r;
            if (bi.blk_valid && r) blk_i++;
        end
        if (!fin) chk("done_timeout", 128'd0, 128'd1);
        chk("reads", 128'(rd_i), 128'((l == 0) ? 0 : nb));
        nblk_got = blk_i;
        bi.blk_ready = 1'b0;
        @(negedge clk);
        chk("done_pulse", {127'd0, done}, 128'd0);
        chk("busy_after", {127'd0, busy}, 128'd0);
    endtask

    typedef struct {
        int   len;
        int   pct;
        int   stall;
        int   exp_nblk;
        logic exp_cmpl;
        int   exp_first;
        int   exp_done;
    } vec_t;

    initial begin
        vec_t vt[10];
        int nbg, fc, dc, hs, cyc;
        logic cg;
        logic [127:0] ld, exp200;
        bit hit;

`ifdef CMAC_PAD_EN
        exp200 = 128'hFFFF_FFFF_FFFF_FFFF_FF80_0000_0000_0000;
`else
        exp200 = 128'hFFFF_FFFF_FFFF_FFFF_FF00_0000_0000_0000;
`endif
        vt[0] = '{256,   100, 0,  2,   1'b1, 3, 7};
        vt[1] = '{34176, 100, 0,  267, 1'b1, 3, 802};
        vt[2] = '{200,   100, 0,  2,   1'b0, 3, 7};
        vt[3] = '{0,     100, 0,  1,   1'b0, 1, 2};
        vt[4] = '{128,   100, 0,  1,   1'b1, 3, 4};
        vt[5] = '{1,     100, 0,  1,   1'b0, 3, 4};
        vt[6] = '{129,   100, 0,  2,   1'b0, 3, 7};
        vt[7] = '{65535, 100, 0,  512, 1'b0, 3, 1537};
        vt[8] = '{384,   100, 10, 3,   1'b1, 3, 20};
        vt[9] = '{1000,  60,  0,  8,   1'b0, 3, -1};

        for (int i = 0; i < 512; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
        mem[1] = '1;
        bi.blk_ready = 1'b0;

        #12;
        chk("reset_outs", {bi.bram_en, bi.bram_addr, bi.blk_valid, bi.blk_last,
                           bi.blk_complete, busy, done, err}, 128'd0);
        chk("reset_data", bi.blk_data, 128'd0);
        chk("reset_ovf", {125'd0, err_o, busy_o, bo.bram_en}, 128'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            run_msg(vt[i].len, vt[i].pct, vt[i].stall, nbg, fc, dc, cg, ld);
            chk($sformatf("v%0d_nblk", i), 128'(nbg), 128'(vt[i].exp_nblk));
            chk($sformatf("v%0d_cmpl", i), {127'd0, cg}, {127'd0, vt[i].exp_cmpl});
            chk($sformatf("v%0d_first", i), 128'(fc), 128'(vt[i].exp_first));
            if (vt[i].exp_done >= 0) chk($sformatf("v%0d_done_cyc", i), 128'(dc), 128'(vt[i].exp_done));
            if (vt[i].len == 200) chk("len200_tail", ld, exp200);
        end

        for (int i = 0; i < 6; i++) begin
            int l;
            l = $urandom_range(0, 1500);
            run_msg(l, $urandom_range(25, 100), 0, nbg, fc, dc, cg, ld);
            chk($sformatf("rnd%0d_nblk", i), 128'(nbg), 128'(model_nblk(l)));
        end

        // Reset while block index 4 of a 10-block message is on offer.
        bi.blk_ready = 1'b1;
        @(negedge clk);
        start = 1'b1; len_in = 16'd1280;
        hs = 0; hit = 0; cyc = 0;
        while (!hit && cyc < 100) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (bi.blk_valid) begin
                if (hs == 4) hit = 1;
                else hs++;
            end
        end
        chk("midrst_reached", {127'd0, hit}, 128'd1);
        reset = 1'b0;
        #1;
        chk("midrst_outs", {bi.bram_en, bi.bram_addr, bi.blk_valid, bi.blk_last,
                            bi.blk_complete, busy, done, err}, 128'd0);
        chk("midrst_data", bi.blk_data, 128'd0);
        bi.blk_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("midrst_nodone", {126'd0, done, busy}, 128'd0);
        end
        reset = 1'b1;
        start = 1'b1; len_in = 16'd256;
        @(negedge clk);
        start = 1'b0;
        chk("rel_start_ign", {126'd0, busy, bi.bram_en}, 128'd0);
        @(negedge clk);
        chk("rel_start_ign2", {126'd0, busy, bi.bram_en}, 128'd0);
        run_msg(128, 100, 0, nbg, fc, dc, cg, ld);
        chk("post_rst_nblk", 128'(nbg), 128'd1);

        // Overflow instance: BASE_ADDR 500 leaves room for 12 blocks.
        @(negedge clk);
        start_o = 1'b1; len_o = 16'd2048;
        @(negedge clk);
        start_o = 1'b0;
        chk("ovf_err", {125'd0, err_o, busy_o, bo.bram_en}, 128'd4);
        @(negedge clk);
        chk("ovf_after", {125'd0, err_o, busy_o, bo.bram_en}, 128'd0);
        start_o = 1'b1; len_o = 16'd1536;
        @(negedge clk);
        start_o = 1'b0;
        chk("fit_start", {125'd0, err_o, busy_o, bo.bram_en}, 128'd3);
        chk("fit_addr", {119'd0, bo.bram_addr}, 128'd500);
        cyc = 1;
        while (!done_o && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("fit_done_cyc", 128'(cyc), 128'd37);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
